de2_115_reset_conditioner: RTL and testbench
============================================

# de2_115_reset_conditioner

Upstream of the board clocks/resets block. Turns three raw reset sources into one clean, glitch-free, minimum-width active-high reset that drives the clocks/resets block's board reset input. The sources are the asynchronous power-on/external reset, the bouncing KEY0 pushbutton and a software reset request from the system domain. It also reports the cause of the last reset and a saturating reset counter for boot firmware.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, cycles KEY0 must stay pressed (synchronised) before a reset is taken (10 ms at 50 MHz); minimum 2.
- STRETCH_CYCLES, 1024, minimum o_rst high time in i_brd_clk cycles; minimum 2.
- SYNC_STAGES, 2, synchroniser depth for i_key_n and i_sw_rst_req; minimum 2.

Ports:
- i_brd_clk  input  1  board clock (50 MHz).
- i_brd_rst  input  1  reset i_brd_rst, asynchronous, active-high (power-on/external).
- i_key_n  input  1  KEY0, active-low, asynchronous, bouncy.
- i_sw_rst_req  input  1  software reset request, level, active-high, asynchronous to i_brd_clk.
- o_rst  output  1  conditioned reset, active-high, registered.
- o_rst_cause  output  2  last reset cause: 00 POR, 01 key, 10 software; 11 never produced.
- o_rst_count  output  8  number of key/software resets since POR, saturates at 255.

## Operation
- Synchronisers: i_key_n and i_sw_rst_req each pass through SYNC_STAGES flops.
  - On i_brd_rst the key chain resets to 1 (released) and the sw chain to 0.
  - All FSM logic uses only the synchronised values key_s and sw_s.
- One shared counter, width $clog2(max(DEBOUNCE_CYCLES, STRETCH_CYCLES)). It is cleared on every state entry.
- FSM states: STRETCH, RUN, DEBOUNCE.
- i_brd_rst asserted (async) sets:
  - state = STRETCH, cnt = 0, o_rst = 1, o_rst_cause = 00, o_rst_count = 0.
- STRETCH: o_rst = 1.
  - cnt increments until it reaches STRETCH_CYCLES-1, then holds.
  - At cnt == STRETCH_CYCLES-1 with key_s = 1 and sw_s = 0: go to RUN, o_rst <= 0.
  - Otherwise stay, so a held key or request extends the reset indefinitely.
- RUN: o_rst = 0.
  - sw_s = 1: go to STRETCH, cause <= 10, count++. This has priority over the key.
  - Else key_s = 0: go to DEBOUNCE.
- DEBOUNCE: o_rst = 0.
  - sw_s = 1: go to STRETCH, cause <= 10, count++ (priority).
  - Else key_s = 1: back to RUN. The glitch is rejected: no count change, no cause change.
  - Else cnt == DEBOUNCE_CYCLES-1: go to STRETCH, cause <= 01, count++.
  - Else cnt++.
- o_rst_count increments only on transitions into STRETCH from RUN or DEBOUNCE, and holds at 255.
- o_rst_cause and o_rst_count are not cleared by o_rst. They are cleared only by i_brd_rst.
- o_rst comes directly from a flop with no combinational path to the output.

## Timing
- i_brd_rst assert: o_rst = 1 immediately (async). This is the only asynchronous assertion path.
- i_brd_rst deassert with inputs idle: o_rst falls on the STRETCH_CYCLES-th rising edge after release.
- Any entry to STRETCH: o_rst rises on the entering edge and stays high for at least STRETCH_CYCLES cycles.
- Key press held steady from RUN:
  - The FSM sees key_s low SYNC_STAGES edges after i_key_n falls.
  - DEBOUNCE is entered 1 edge later.
  - o_rst rises DEBOUNCE_CYCLES edges after DEBOUNCE entry.
  - Total: SYNC_STAGES+1+DEBOUNCE_CYCLES edges.
- A key low pulse shorter than DEBOUNCE_CYCLES synchronised cycles never asserts o_rst.
- Software request from RUN: o_rst rises SYNC_STAGES+1 edges after i_sw_rst_req rises.
- Release bounce: bounces during STRETCH are ignored except at the terminal count. Bounces after RUN is entered fall under the glitch-rejection rule.
- Simultaneous sw_s and key_s events: software wins and cause = 10.
- i_brd_rst in any state, mid-debounce or mid-stretch: full reinitialisation and cause = 00.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=16, STRETCH_CYCLES=8, SYNC_STAGES=2.
- POR: assert i_brd_rst for 3 cycles, then release with i_key_n=1 and i_sw_rst_req=0 -> o_rst high until the 8th edge after release, then 0; o_rst_cause=00; o_rst_count=0.
- Glitch reject: i_key_n low for 10 cycles, and separately bounce 1/0 every 3 cycles for 40 cycles -> o_rst stays 0; o_rst_count stays 0.
- Key reset: i_key_n low and held 40 cycles -> o_rst rises exactly 19 edges after the fall and stays high until key_s has been high and the stretch is done; o_rst_cause=01; o_rst_count=1.
- Software reset: pulse i_sw_rst_req for 2 cycles in RUN -> o_rst rises 3 edges later and is high for exactly 8 cycles; o_rst_cause=10. Holding the request for 30 cycles keeps o_rst high until 3 edges after the request falls.
- Priority/saturation: raise i_sw_rst_req 5 cycles into DEBOUNCE -> cause=10 and count increments once. Then 260 software resets -> o_rst_count=255.
- Async mid-operation: assert i_brd_rst during STRETCH (count=7) -> o_rst stays 1; cause=00; count=0; the stretch restarts from 0 after release.

Source files
------------

// File: rtl/de2_115_reset_conditioner.sv
// DE2-115 reset conditioner: POR, debounced KEY0 and software request
// merged into one stretched reset, with last-cause and reset counter.
module de2_115_reset_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STRETCH_CYCLES  = 1024,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       i_brd_clk,
  input  logic       i_brd_rst,
  input  logic       i_key_n,
  input  logic       i_sw_rst_req,
  output logic       o_rst,
  output logic [1:0] o_rst_cause,
  output logic [7:0] o_rst_count
);

  localparam int MAXC =
    (DEBOUNCE_CYCLES > STRETCH_CYCLES) ?
    DEBOUNCE_CYCLES : STRETCH_CYCLES;
  localparam int CW = $clog2(MAXC);

  localparam logic [CW-1:0] STR_END =
    CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] DEB_END =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_KEY = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    ST_STRETCH,
    ST_RUN,
    ST_DEBOUNCE
  } state_t;

  logic [SYNC_STAGES-1:0] key_sync;
  logic [SYNC_STAGES-1:0] sw_sync;
  logic                   key_s;
  logic                   sw_s;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [1:0]    cause_d;
  logic [7:0]    count_d;
  logic [7:0]    count_inc;
  logic          rst_d;

  // Synchronise key (idles released) and sw request (idles low)
  always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
    if (i_brd_rst) begin
      key_sync <= '1;
      sw_sync  <= '0;
    end else begin
      key_sync <= {key_sync[SYNC_STAGES-2:0], i_key_n};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], i_sw_rst_req};
    end
  end

  assign key_s = key_sync[SYNC_STAGES-1];
  assign sw_s  = sw_sync[SYNC_STAGES-1];

  assign count_inc = (o_rst_count == 8'hFF) ?
                     o_rst_count : o_rst_count + 8'd1;

  // Next state, shared counter, cause/count bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = o_rst_cause;
    count_d = o_rst_count;
    unique case (state_q)
      ST_STRETCH: begin
        if (cnt_q != STR_END) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (key_s && !sw_s) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (sw_s) begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
          cause_d = CAUSE_SW;
          count_d = count_inc;
        end else if (!key_s) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (sw_s) begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
          cause_d = CAUSE_SW;
          count_d = count_inc;
        end else if (key_s) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_END) begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
          cause_d = CAUSE_KEY;
          count_d = count_inc;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STRETCH;
        cnt_d   = '0;
      end
    endcase
    rst_d = (state_d == ST_STRETCH);
  end

  // State, counter and registered outputs; POR reinitialises all
  always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
    if (i_brd_rst) begin
      state_q     <= ST_STRETCH;
      cnt_q       <= '0;
      o_rst       <= 1'b1;
      o_rst_cause <= CAUSE_POR;
      o_rst_count <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      o_rst       <= rst_d;
      o_rst_cause <= cause_d;
      o_rst_count <= count_d;
    end
  end

endmodule

// File: tb/tb_de2_115_reset_conditioner.sv
// Bench for de2_115_reset_conditioner: cycle model plus
// directed literal checks on POR, key, software and saturation.
module tb_de2_115_reset_conditioner;

  localparam int D = 16;
  localparam int S = 8;

  logic       i_brd_clk    = 1'b0;
  logic       i_brd_rst    = 1'b1;
  logic       i_key_n      = 1'b1;
  logic       i_sw_rst_req = 1'b0;
  logic       o_rst;
  logic [1:0] o_rst_cause;
  logic [7:0] o_rst_count;

  int tests = 0;
  int fails = 0;

  de2_115_reset_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .STRETCH_CYCLES (S),
    .SYNC_STAGES    (2)
  ) dut (
    .i_brd_clk   (i_brd_clk),
    .i_brd_rst   (i_brd_rst),
    .i_key_n     (i_key_n),
    .i_sw_rst_req(i_sw_rst_req),
    .o_rst       (o_rst),
    .o_rst_cause (o_rst_cause),
    .o_rst_count (o_rst_count)
  );

  always #5 i_brd_clk = ~i_brd_clk;

  // Model: reset "age" and run-length of low key samples
  bit m_rst   = 1'b1;
  int age     = 0;
  int low_run = 0;
  int m_cause = 0;
  int m_count = 0;
  bit ka = 1'b1, kb = 1'b1, sa = 1'b0, sb = 1'b0;

  function automatic void m_enter(int c);
    m_rst   = 1'b1;
    age     = 0;
    low_run = 0;
    m_cause = c;
    if (m_count < 255) m_count++;
  endfunction

  initial forever begin
    bit key_seen, sw_seen;
    @(posedge i_brd_clk or posedge i_brd_rst);
    if (i_brd_rst) begin
      ka = 1'b1; kb = 1'b1; sa = 1'b0; sb = 1'b0;
      m_rst = 1'b1; age = 0; low_run = 0;
      m_cause = 0; m_count = 0;
    end else begin
      key_seen = kb;
      sw_seen  = sb;
      kb = ka; ka = i_key_n;
      sb = sa; sa = i_sw_rst_req;
      if (m_rst) begin
        if (age < S) age++;
        if (age >= S && key_seen && !sw_seen) begin
          m_rst   = 1'b0;
          low_run = 0;
        end
      end else if (sw_seen) begin
        m_enter(2);
      end else if (!key_seen) begin
        low_run++;
        if (low_run == D + 1) m_enter(1);
      end else begin
        low_run = 0;
      end
    end
  end

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge
  initial forever begin
    @(negedge i_brd_clk);
    check("m_rst",   int'(o_rst),       int'(m_rst));
    check("m_cause", int'(o_rst_cause), m_cause);
    check("m_count", int'(o_rst_count), m_count);
  end

  task automatic edges(int n);
    repeat (n) @(negedge i_brd_clk);
  endtask

  initial begin
    // POR
    edges(3);
    i_brd_rst = 1'b0;
    edges(7);
    check("por_hold", int'(o_rst), 1);
    edges(1);
    check("por_rel", int'(o_rst), 0);
    check("por_cause", int'(o_rst_cause), 0);
    check("por_count", int'(o_rst_count), 0);

    // Glitch reject: short low, then bouncing
    i_key_n = 1'b0;
    edges(10);
    i_key_n = 1'b1;
    edges(10);
    for (int i = 0; i < 40; i++) begin
      i_key_n = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      edges(1);
    end
    i_key_n = 1'b1;
    edges(5);
    check("glitch_rst", int'(o_rst), 0);
    check("glitch_count", int'(o_rst_count), 0);

    // Key held 40 cycles
    i_key_n = 1'b0;
    edges(18);
    check("key_e18", int'(o_rst), 0);
    edges(1);
    check("key_e19", int'(o_rst), 1);
    edges(21);
    i_key_n = 1'b1;
    edges(2);
    check("key_rel2", int'(o_rst), 1);
    edges(1);
    check("key_rel3", int'(o_rst), 0);
    check("key_cause", int'(o_rst_cause), 1);
    check("key_count", int'(o_rst_count), 1);

    // Software pulse
    i_sw_rst_req = 1'b1;
    edges(2);
    check("sw_e2", int'(o_rst), 0);
    i_sw_rst_req = 1'b0;
    edges(1);
    check("sw_e3", int'(o_rst), 1);
    edges(7);
    check("sw_e10", int'(o_rst), 1);
    edges(1);
    check("sw_e11", int'(o_rst), 0);
    check("sw_cause", int'(o_rst_cause), 2);
    check("sw_count", int'(o_rst_count), 2);

    // Software request held 30 cycles
    i_sw_rst_req = 1'b1;
    edges(30);
    i_sw_rst_req = 1'b0;
    edges(2);
    check("swh_e2", int'(o_rst), 1);
    edges(1);
    check("swh_e3", int'(o_rst), 0);
    check("swh_count", int'(o_rst_count), 3);

    // Software wins during debounce
    i_key_n = 1'b0;
    edges(8);
    i_sw_rst_req = 1'b1;
    edges(2);
    check("pri_e2", int'(o_rst), 0);
    edges(1);
    check("pri_e3", int'(o_rst), 1);
    check("pri_cause", int'(o_rst_cause), 2);
    check("pri_count", int'(o_rst_count), 4);
    i_key_n = 1'b1;
    i_sw_rst_req = 1'b0;
    edges(15);
    check("pri_rel", int'(o_rst), 0);
    check("pri_count2", int'(o_rst_count), 4);

    // Saturation
    for (int i = 0; i < 260; i++) begin
      i_sw_rst_req = 1'b1;
      edges(2);
      i_sw_rst_req = 1'b0;
      edges(12);
    end
    check("sat_count", int'(o_rst_count), 255);
    check("sat_cause", int'(o_rst_cause), 2);

    // Async POR in mid-stretch
    i_sw_rst_req = 1'b1;
    edges(2);
    i_sw_rst_req = 1'b0;
    edges(8);
    check("mid_rst", int'(o_rst), 1);
    #2 i_brd_rst = 1'b1;
    #1;
    check("async_rst", int'(o_rst), 1);
    check("async_cause", int'(o_rst_cause), 0);
    check("async_count", int'(o_rst_count), 0);
    @(negedge i_brd_clk);
    edges(1);
    i_brd_rst = 1'b0;
    edges(7);
    check("re_hold", int'(o_rst), 1);
    edges(1);
    check("re_rel", int'(o_rst), 0);
    check("re_count", int'(o_rst_count), 0);
    edges(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
